// File: rtl/mega_sound_latch_pkg.sv
// Shared types and constants for the main/sound 68000 latch pair.
// Imported by the bus tracker and the latch top.
package mega_sound_latch_pkg;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_WAIT,
    TRK_ACK
  } trk_state_e;

  localparam int DTACK_WAIT_DEF = 2;
  localparam int SND_IRQ_LEVEL_DEF = 4;
  localparam logic [2:0] FC_IACK = 3'b111;

  function automatic logic [15:0] merge_bytes(
    input logic [15:0] old_v,
    input logic [15:0] new_v,
    input logic        uds_n,
    input logic        lds_n
  );
    merge_bytes = old_v;
    if (!uds_n) merge_bytes[15:8] = new_v[15:8];
    if (!lds_n) merge_bytes[7:0] = new_v[7:0];
  endfunction

endpackage

// File: rtl/mega_sound_latch_bus_tracker.sv
// Per-CPU latch access tracker: arming, start pulse, DTACK countdown
// and the hold window for registered read data.
module latch_bus_tracker
  import mega_sound_latch_pkg::*;
#(
  parameter int DTACK_WAIT = DTACK_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_i,
  input  logic as_n_i,
  input  logic uds_n_i,
  input  logic lds_n_i,
  output logic start_o,
  output logic dtack_n_o,
  output logic hold_o
);

  localparam logic [2:0] WAIT_L = 3'(DTACK_WAIT);

  trk_state_e state_q;
  logic [2:0] cnt_q;
  logic       armed_q;
  logic       dtack_q;
  logic       access;

  assign access    = cs_i & ~as_n_i & (~uds_n_i | ~lds_n_i);
  assign start_o   = armed_q & access;
  assign hold_o    = (state_q != TRK_IDLE) & ~as_n_i;
  assign dtack_n_o = dtack_q;

  // Arming needs as_n seen high, so a cycle straddling reset is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TRK_IDLE;
      cnt_q   <= 3'd0;
      armed_q <= 1'b0;
      dtack_q <= 1'b1;
    end else if (as_n_i) begin
      state_q <= TRK_IDLE;
      cnt_q   <= 3'd0;
      armed_q <= 1'b1;
      dtack_q <= 1'b1;
    end else begin
      case (state_q)
        TRK_IDLE: begin
          if (start_o) begin
            state_q <= TRK_WAIT;
            cnt_q   <= WAIT_L;
            armed_q <= 1'b0;
          end
        end
        TRK_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_q <= TRK_ACK;
            cnt_q   <= 3'd0;
            dtack_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        TRK_ACK: dtack_q <= 1'b0;
        default: state_q <= TRK_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mega_sound_latch.sv
// Bidirectional command/reply latch between main and sound 68000s,
// with per-CPU DTACK and the sound-CPU interrupt request.
module mega_sound_latch
  import mega_sound_latch_pkg::*;
#(
  parameter int DTACK_WAIT    = DTACK_WAIT_DEF,
  parameter int SND_IRQ_LEVEL = SND_IRQ_LEVEL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68kp_latch0_cs,
  input  logic        m68kp_latch1_cs,
  input  logic        m68kp_as_n,
  input  logic        m68kp_rw,
  input  logic        m68kp_uds_n,
  input  logic        m68kp_lds_n,
  input  logic [15:0] m68kp_dout,
  output logic [15:0] m68kp_din,
  output logic        m68kp_dtack_n,
  input  logic        m68ks_latch0_cs,
  input  logic        m68ks_latch1_cs,
  input  logic        m68ks_as_n,
  input  logic        m68ks_rw,
  input  logic        m68ks_uds_n,
  input  logic        m68ks_lds_n,
  input  logic [15:0] m68ks_dout,
  output logic [15:0] m68ks_din,
  output logic        m68ks_dtack_n,
  input  logic [2:0]  m68ks_fc,
  input  logic [2:0]  m68ks_a3_1,
  output logic [2:0]  m68ks_ipl_n,
  output logic        cmd_pending,
  output logic        reply_pending
);

  localparam logic [2:0] IRQ_LVL = 3'(SND_IRQ_LEVEL);

  logic m_start, m_hold, s_start, s_hold;
  logic s_iack, iack_start;
  logic m_wr0, m_rd1, s_wr1, s_rd0;

  logic [15:0] latch0_q, latch0_d;
  logic [15:0] latch1_q, latch1_d;
  logic [15:0] sdin_q, sdin_d;
  logic [15:0] pdin_q, pdin_d;
  logic        cmd_q, cmd_d;
  logic        reply_q, reply_d;
  logic        irq_q, irq_d;
  logic [2:0]  ipl_q, ipl_d;
  logic        as_prev_q;

  assign s_iack = (m68ks_fc == FC_IACK);

  latch_bus_tracker #(.DTACK_WAIT(DTACK_WAIT)) u_main_trk (
    .clk_i     (clk),
    .rst_i     (reset),
    .cs_i      (m68kp_latch0_cs | m68kp_latch1_cs),
    .as_n_i    (m68kp_as_n),
    .uds_n_i   (m68kp_uds_n),
    .lds_n_i   (m68kp_lds_n),
    .start_o   (m_start),
    .dtack_n_o (m68kp_dtack_n),
    .hold_o    (m_hold)
  );

  // IACK cycles are autovectored elsewhere, so never track them here.
  latch_bus_tracker #(.DTACK_WAIT(DTACK_WAIT)) u_snd_trk (
    .clk_i     (clk),
    .rst_i     (reset),
    .cs_i      ((m68ks_latch0_cs | m68ks_latch1_cs) & ~s_iack),
    .as_n_i    (m68ks_as_n),
    .uds_n_i   (m68ks_uds_n),
    .lds_n_i   (m68ks_lds_n),
    .start_o   (s_start),
    .dtack_n_o (m68ks_dtack_n),
    .hold_o    (s_hold)
  );

  assign m_wr0 = m_start & ~m68kp_rw & m68kp_latch0_cs;
  assign m_rd1 = m_start & m68kp_rw & m68kp_latch1_cs;
  assign s_wr1 = s_start & ~m68ks_rw & m68ks_latch1_cs;
  assign s_rd0 = s_start & m68ks_rw & m68ks_latch0_cs;

  assign iack_start = s_iack & (m68ks_a3_1 == IRQ_LVL)
                    & ~m68ks_as_n & as_prev_q;

  // Reads sample the old latch value; a same-clock write wins the flag.
  always_comb begin
    latch0_d = latch0_q;
    latch1_d = latch1_q;
    if (m_wr0)
      latch0_d = merge_bytes(latch0_q, m68kp_dout,
                             m68kp_uds_n, m68kp_lds_n);
    if (s_wr1)
      latch1_d = merge_bytes(latch1_q, m68ks_dout,
                             m68ks_uds_n, m68ks_lds_n);

    sdin_d = sdin_q;
    if (s_rd0)       sdin_d = latch0_q;
    else if (!s_hold) sdin_d = 16'h0000;

    pdin_d = pdin_q;
    if (m_rd1)       pdin_d = latch1_q;
    else if (!m_hold) pdin_d = 16'h0000;

    cmd_d = cmd_q;
    if (m_wr0)      cmd_d = 1'b1;
    else if (s_rd0) cmd_d = 1'b0;

    reply_d = reply_q;
    if (s_wr1)      reply_d = 1'b1;
    else if (m_rd1) reply_d = 1'b0;

    irq_d = irq_q;
    if (m_wr0)           irq_d = 1'b1;
    else if (iack_start) irq_d = 1'b0;

    ipl_d = irq_d ? ~IRQ_LVL : 3'b111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch0_q  <= 16'h0000;
      latch1_q  <= 16'h0000;
      sdin_q    <= 16'h0000;
      pdin_q    <= 16'h0000;
      cmd_q     <= 1'b0;
      reply_q   <= 1'b0;
      irq_q     <= 1'b0;
      ipl_q     <= 3'b111;
      as_prev_q <= 1'b0;
    end else begin
      latch0_q  <= latch0_d;
      latch1_q  <= latch1_d;
      sdin_q    <= sdin_d;
      pdin_q    <= pdin_d;
      cmd_q     <= cmd_d;
      reply_q   <= reply_d;
      irq_q     <= irq_d;
      ipl_q     <= ipl_d;
      as_prev_q <= m68ks_as_n;
    end
  end

  assign m68ks_din     = sdin_q;
  assign m68kp_din     = pdin_q;
  assign cmd_pending   = cmd_q;
  assign reply_pending = reply_q;
  assign m68ks_ipl_n   = ipl_q;

endmodule
